// File: rtl/eaglesong_pkg.sv
// Shared constants and types for the Eaglesong sponge controller and its engine.
package eaglesong_pkg;

    localparam int WORD_W         = 32;
    localparam int STATE_WORDS    = 16;
    localparam int RATE_WORDS_DEF = 8;
    localparam int NUM_ROUNDS     = 43;
    localparam int ENGINE_LATENCY = 44;

    typedef logic [STATE_WORDS-1:0][WORD_W-1:0] state_t;

    typedef enum logic [2:0] {
        ACCEPT,
        START,
        ARM,
        WAIT,
        SETTLE,
        DONE,
        ERROR
    } fsm_t;

endpackage

// File: rtl/eaglesong_sponge_ctrl.sv
// Sponge sequencer: absorbs rate words into the 512-bit state, runs one
// permutation per block, and hands out the digest once the last block is in.
module eaglesong_sponge_ctrl
    import eaglesong_pkg::*;
#(
    parameter int RATE_WORDS     = RATE_WORDS_DEF,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                blk_valid,
    output logic                                blk_ready,
    input  logic [RATE_WORDS-1:0][WORD_W-1:0]   blk_data,
    input  logic                                blk_last,
    output logic                                digest_valid,
    input  logic                                digest_ready,
    output logic [RATE_WORDS-1:0][WORD_W-1:0]   digest,
    output logic                                perm_start,
    output state_t                              perm_state_in,
    input  state_t                              perm_state_out,
    input  logic                                perm_ready,
    output logic                                busy,
    output logic                                err,
    output logic [15:0]                         blk_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    fsm_t             state;
    fsm_t             next;
    state_t           st;
    logic             last_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             blk_fire;
    logic             digest_fire;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign blk_fire      = blk_valid && blk_ready;
    assign digest_fire   = digest_valid && digest_ready;
    assign perm_state_in = st;
    assign digest        = st[RATE_WORDS-1:0];

    always_comb begin
        next = state;
        unique case (state)
            ACCEPT: if (blk_fire) next = START;
            START:  next = ARM;
            // perm_ready is stale or unknown right after the start pulse
            ARM:    next = WAIT;
            WAIT: begin
                if (perm_ready)
                    next = SETTLE;
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES))
                    next = ERROR;
            end
            SETTLE: next = last_q ? DONE : ACCEPT;
            DONE:   if (digest_fire) next = ACCEPT;
            ERROR:  next = ERROR;
            default: next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ACCEPT;
            st           <= '0;
            last_q       <= 1'b0;
            tmo_cnt      <= '0;
            blk_count    <= '0;
            blk_ready    <= 1'b1;
            digest_valid <= 1'b0;
            perm_start   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= next;
            blk_ready    <= (next == ACCEPT);
            digest_valid <= (next == DONE);
            perm_start   <= (next == START);
            busy         <= (next != ACCEPT);
            err          <= err | (next == ERROR);

            unique case (state)
                ACCEPT: begin
                    if (blk_fire) begin
                        for (int i = 0; i < RATE_WORDS; i++)
                            st[i] <= st[i] ^ blk_data[i];
                        last_q    <= blk_last;
                        blk_count <= sat_inc16(blk_count);
                    end
                end
                ARM: tmo_cnt <= '0;
                WAIT: begin
                    if (!perm_ready && tmo_cnt != TMO_W'(TIMEOUT_CYCLES))
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                // engine data is only trustworthy one cycle after ready rises
                SETTLE: st <= perm_state_out;
                DONE: begin
                    if (digest_fire) begin
                        st        <= '0;
                        blk_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Directed bench for eaglesong_sponge_ctrl with a behavioural engine stub.
module tb_eaglesong_sponge_ctrl;
    import eaglesong_pkg::*;

    localparam int NORMAL = 0;
    localparam int NEVER  = 1;
    localparam int STALE  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             blk_valid;
    logic             blk_ready;
    logic [7:0][31:0] blk_data;
    logic             blk_last;
    logic             digest_valid;
    logic             digest_ready;
    logic [7:0][31:0] digest;
    logic             perm_start;
    state_t           perm_state_in;
    state_t           perm_state_out;
    logic             perm_ready;
    logic             busy;
    logic             err;
    logic [15:0]      blk_count;

    int     mode = NORMAL;
    logic   running = 1'b0;
    int     ecnt = 0;
    state_t eng_in = '0;
    int     start_cnt = 0;
    int     n_chk = 0;
    int     n_pass = 0;

    always #5 clk = ~clk;

    eaglesong_sponge_ctrl #(.RATE_WORDS(8), .TIMEOUT_CYCLES(63)) dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
        .perm_start(perm_start), .perm_state_in(perm_state_in), .perm_state_out(perm_state_out),
        .perm_ready(perm_ready), .busy(busy), .err(err), .blk_count(blk_count)
    );

    // Stand-in permutation: any fixed nonlinear-ish mix of the 16 words will do.
    function automatic state_t model_perm(input state_t s);
        state_t      r;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w    = s[(i + 3) % 16];
            r[i] = {w[26:0], w[31:27]} ^ s[i] ^ (32'h01000193 * 32'(i + 1));
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (perm_start) begin
            running   <= 1'b1;
            ecnt      <= 1;
            eng_in    <= perm_state_in;
            start_cnt <= start_cnt + 1;
        end else if (running && ecnt < 1000) begin
            ecnt <= ecnt + 1;
        end
    end

    assign perm_ready = (mode != NEVER) && running &&
                        (ecnt >= 44 || (mode == STALE && ecnt == 1));
    assign perm_state_out = (running && ecnt >= 45) ? model_perm(eng_in) : {16{32'hDEADBEEF}};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_block(input string tag, input logic [7:0][31:0] d, input logic last);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (blk_ready) break;
        end
        chk({tag, "_rdy"}, 256'(blk_ready), 256'(1));
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = last;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
    endtask

    task automatic wait_digest(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (digest_valid) break;
        end
    endtask

    task automatic take_digest();
        digest_ready = 1'b1;
        @(posedge clk);
        #1;
        digest_ready = 1'b0;
    endtask

    initial begin
        state_t           zs;
        state_t           s;
        logic [7:0][31:0] zero_dig;
        logic [7:0][31:0] exp2;
        logic [7:0][31:0] d;
        logic [7:0][31:0] saved;
        logic             stable;
        logic             rdy_seen;
        int               cyc;
        int               k;
        int               s0;

        rst_n        = 1'b0;
        blk_valid    = 1'b0;
        blk_data     = '0;
        blk_last     = 1'b0;
        digest_ready = 1'b0;

        zs       = model_perm('0);
        zero_dig = zs[7:0];
        s        = '0;
        s[0]     = 32'h00000001;
        s        = model_perm(s);
        for (int i = 0; i < 8; i++) s[i] = s[i] ^ 32'hFFFFFFFF;
        s        = model_perm(s);
        exp2     = s[7:0];

        do_reset();
        chk("rst_blk_ready", 256'(blk_ready), 256'(1));
        chk("rst_digest_valid", 256'(digest_valid), 256'(0));
        chk("rst_perm_start", 256'(perm_start), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_blk_count", 256'(blk_count), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_digest", 256'(digest), 256'(0));

        // single all-zero block with last
        send_block("single", '0, 1'b1);
        wait_digest(cyc);
        chk("single_latency", 256'(cyc), 256'(47));
        chk("single_digest", 256'(digest), 256'(zero_dig));
        chk("single_count", 256'(blk_count), 256'(1));
        chk("single_busy", 256'(busy), 256'(1));
        take_digest();
        @(negedge clk);
        chk("single_after_ready", 256'(blk_ready), 256'(1));
        chk("single_after_count", 256'(blk_count), 256'(0));

        // two blocks
        d = '0;
        d[0] = 32'h00000001;
        send_block("two_a", d, 1'b0);
        d = {8{32'hFFFFFFFF}};
        send_block("two_b", d, 1'b1);
        wait_digest(cyc);
        chk("two_latency", 256'(cyc), 256'(47));
        chk("two_digest", 256'(digest), 256'(exp2));
        chk("two_count", 256'(blk_count), 256'(2));

        // hold the digest with a stray block offered meanwhile
        saved     = digest;
        stable    = 1'b1;
        rdy_seen  = 1'b0;
        blk_valid = 1'b1;
        blk_data  = {8{32'h12345678}};
        repeat (20) begin
            @(negedge clk);
            if (digest !== saved || !digest_valid) stable = 1'b0;
            if (blk_ready) rdy_seen = 1'b1;
        end
        blk_valid = 1'b0;
        chk("hold_stable", 256'(stable), 256'(1));
        chk("hold_blk_ready", 256'(rdy_seen), 256'(0));
        chk("hold_count", 256'(blk_count), 256'(2));
        take_digest();
        send_block("fresh", '0, 1'b1);
        wait_digest(cyc);
        chk("fresh_latency", 256'(cyc), 256'(47));
        chk("fresh_digest", 256'(digest), 256'(zero_dig));
        take_digest();

        // engine never answers
        mode = NEVER;
        send_block("tmo", '0, 1'b1);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) break;
            k++;
        end
        chk("tmo_cycles", 256'(k), 256'(66));
        blk_valid    = 1'b1;
        digest_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("tmo_err_hold", 256'(err), 256'(1));
        chk("tmo_busy", 256'(busy), 256'(1));
        chk("tmo_blk_ready", 256'(blk_ready), 256'(0));
        chk("tmo_digest_valid", 256'(digest_valid), 256'(0));
        chk("tmo_count", 256'(blk_count), 256'(1));
        blk_valid    = 1'b0;
        digest_ready = 1'b0;
        do_reset();
        mode = NORMAL;
        chk("tmo_rst_err", 256'(err), 256'(0));
        chk("tmo_rst_busy", 256'(busy), 256'(0));
        chk("tmo_rst_blk_ready", 256'(blk_ready), 256'(1));
        chk("tmo_rst_count", 256'(blk_count), 256'(0));
        chk("tmo_rst_digest", 256'(digest), 256'(0));

        // reset in the middle of a permutation
        send_block("abort", {8{32'h55555555}}, 1'b1);
        repeat (20) @(negedge clk);
        do_reset();
        s0 = start_cnt;
        send_block("post_rst", '0, 1'b1);
        wait_digest(cyc);
        chk("post_rst_latency", 256'(cyc), 256'(47));
        chk("post_rst_digest", 256'(digest), 256'(zero_dig));
        chk("post_rst_starts", 256'(start_cnt - s0), 256'(1));
        take_digest();

        // stale ready during ARM, garbage on first ready cycle
        mode = STALE;
        send_block("stale", '0, 1'b1);
        wait_digest(cyc);
        chk("stale_latency", 256'(cyc), 256'(47));
        chk("stale_digest", 256'(digest), 256'(zero_dig));
        take_digest();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
